// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin write-back controller for a small register
// array. Three producers (0 = ALU, 1 = load, 2 = immediate) compete for one
// write port through a valid/ready handshake; two combinational read ports
// serve the datapath.
module writeback_arbiter #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req_valid,
  output logic [2:0]            req_ready,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_data,
  input  logic [ADDR_W-1:0]     rd_addr_a,
  output logic [DATA_W-1:0]     rd_data_a,
  input  logic [ADDR_W-1:0]     rd_addr_b,
  output logic [DATA_W-1:0]     rd_data_b,
  output logic [1:0]            last_grant,
  output logic                  last_grant_vld
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [1:0]        rr_ptr;

  logic              grant_vld;
  logic [1:0]        grant_idx;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Pick the first valid requester starting at rr_ptr and wrapping mod 3.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the loop can leave a value unassigned and infer a latch.
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    for (int k = 0; k < 3; k++) begin
      int cand;
      cand = int'(rr_ptr) + k;
      if (cand >= 3) cand = cand - 3;
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = 2'(cand);
      end
    end
  end

  // Route the granted requester's address and data to the write port.
  always_comb begin
    wr_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
    wr_data = req_data[grant_idx*DATA_W +: DATA_W];
  end

  // Zero-latency one-hot grant; suppressed while reset is held.
  assign req_ready = (grant_vld && !reset) ? (3'b001 << grant_idx) : 3'b000;

  // Combinational reads with no write-to-read bypass; out-of-range reads 0.
  assign rd_data_a = (int'(rd_addr_a) < NUM_REGS) ? regs[rd_addr_a] : '0;
  assign rd_data_b = (int'(rd_addr_b) < NUM_REGS) ? regs[rd_addr_b] : '0;

  // Commit the granted write, advance the pointer, record the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the array is cleared on reset because the datapath relies on
      // reading zeros afterwards; this rules out a plain RAM macro.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      rr_ptr         <= 2'd0;
      last_grant     <= 2'd0;
      last_grant_vld <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling
      // pre-edge values, so reads this cycle still see the old contents.
      last_grant_vld <= grant_vld;
      if (grant_vld) begin
        last_grant <= grant_idx;
        rr_ptr     <= (grant_idx == 2'd2) ? 2'd0 : 2'(grant_idx + 2'd1);
        // Writes to addresses beyond the array are accepted and dropped.
        if (int'(wr_addr) < NUM_REGS) regs[wr_addr] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed steps, with expected
// grants and write results queued at drive time and checked after the edge.
module tb_writeback_arbiter;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [2:0]          req_valid;
  logic [2:0]          req_ready;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_data;
  logic [ADDR_W-1:0]   rd_addr_a, rd_addr_b;
  logic [DATA_W-1:0]   rd_data_a, rd_data_b;
  logic [1:0]          last_grant;
  logic                last_grant_vld;

  writeback_arbiter #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .last_grant(last_grant), .last_grant_vld(last_grant_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              vld;
    logic [1:0]        idx;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_t;

  sb_t               sb[$];
  logic [DATA_W-1:0] model [NUM_REGS];
  int                checks = 0;
  int                errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero();
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_addr_a = 2'(i);
      #1;
      check("reset_reg", {24'd0, rd_data_a}, 32'h0);
    end
  endtask

  // One cycle: drive requests, check the grant and the no-bypass read, queue
  // the expected result, then after the edge compare the queued entry.
  task automatic step(input logic [2:0] v, input logic [5:0] a,
                      input logic [23:0] d, input logic [2:0] exp_rdy);
    sb_t e;
    int  g;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    g      = exp_rdy[1] ? 1 : (exp_rdy[2] ? 2 : 0);
    e.vld  = (exp_rdy != 3'b000);
    e.idx  = 2'(g);
    e.addr = a[g*2 +: 2];
    e.data = d[g*8 +: 8];
    rd_addr_b = e.addr;
    #1;
    check("ready", {29'd0, req_ready}, {29'd0, exp_rdy});
    if (e.vld) check("no_bypass", {24'd0, rd_data_b}, {24'd0, model[e.addr]});
    sb.push_back(e);
    if (e.vld) model[e.addr] = e.data;
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    e = sb.pop_front();
    check("last_grant_vld", {31'd0, last_grant_vld}, {31'd0, e.vld});
    if (e.vld) begin
      check("last_grant", {30'd0, last_grant}, {30'd0, e.idx});
      rd_addr_a = e.addr;
      #1;
      check("write_data", {24'd0, rd_data_a}, {24'd0, model[e.addr]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("init_lg_vld", {31'd0, last_grant_vld}, 32'd0);
    check("init_lg", {30'd0, last_grant}, 32'd0);
    check_all_zero();

    // Single requester: load writes 0xA5 to reg 2.
    step(3'b010, {2'd0, 2'd2, 2'd0}, {8'h00, 8'hA5, 8'h00}, 3'b010);
    // Preload reg 0 and reg 3 so reset has something to clear.
    step(3'b001, {2'd0, 2'd0, 2'd0}, {8'h00, 8'h00, 8'h77}, 3'b001);
    step(3'b100, {2'd3, 2'd0, 2'd0}, {8'h99, 8'h00, 8'h00}, 3'b100);

    // Reset with all requests valid: no grant during reset.
    reset = 1'b1;
    req_valid = 3'b111;
    #1;
    check("reset_ready", {29'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 3'b000;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    check("reset_lg_vld", {31'd0, last_grant_vld}, 32'd0);
    check_all_zero();

    // Full contention: grants 0,1,2,0,1,2.
    step(3'b111, {2'd2, 2'd1, 2'd0}, {8'h32, 8'h21, 8'h10}, 3'b001);
    step(3'b111, {2'd2, 2'd1, 2'd0}, {8'h32, 8'h21, 8'h10}, 3'b010);
    step(3'b111, {2'd2, 2'd1, 2'd0}, {8'h32, 8'h21, 8'h10}, 3'b100);
    step(3'b111, {2'd2, 2'd1, 2'd0}, {8'h62, 8'h51, 8'h40}, 3'b001);
    step(3'b111, {2'd2, 2'd1, 2'd0}, {8'h62, 8'h51, 8'h40}, 3'b010);
    step(3'b111, {2'd2, 2'd1, 2'd0}, {8'h62, 8'h51, 8'h40}, 3'b100);
    rd_addr_a = 2'd0; #1; check("contend_r0", {24'd0, rd_data_a}, 32'h40);
    rd_addr_a = 2'd1; #1; check("contend_r1", {24'd0, rd_data_a}, 32'h51);
    rd_addr_a = 2'd2; #1; check("contend_r2", {24'd0, rd_data_a}, 32'h62);

    // Pointer skip: grant 0, then 2 (skipping idle 1), then 0.
    step(3'b101, {2'd3, 2'd0, 2'd0}, {8'hC2, 8'h00, 8'hC0}, 3'b001);
    step(3'b101, {2'd3, 2'd0, 2'd0}, {8'hC2, 8'h00, 8'hC1}, 3'b100);
    step(3'b001, {2'd0, 2'd0, 2'd0}, {8'h00, 8'h00, 8'hC3}, 3'b001);

    // Bring rr_ptr back to 0, then the same-address race on reg 3.
    step(3'b100, {2'd2, 2'd0, 2'd0}, {8'h6A, 8'h00, 8'h00}, 3'b100);
    step(3'b101, {2'd3, 2'd0, 2'd3}, {8'h22, 8'h00, 8'h11}, 3'b001);
    step(3'b100, {2'd3, 2'd0, 2'd3}, {8'h22, 8'h00, 8'h11}, 3'b100);
    rd_addr_a = 2'd3; #1; check("race_r3", {24'd0, rd_data_a}, 32'h22);

    // No-bypass read: write 0x5C to reg 1 while port B watches reg 1.
    step(3'b010, {2'd0, 2'd1, 2'd0}, {8'h00, 8'h5C, 8'h00}, 3'b010);
    rd_addr_b = 2'd1; #1; check("bypass_next", {24'd0, rd_data_b}, 32'h5C);

    // Idle cycle: no grant, last_grant_vld drops.
    step(3'b000, 6'd0, 24'd0, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
